// File: rtl/disp_mixer.sv
// disp_mixer: priority sprite-layer mixer with frame-stepped brightness fade and 2-clock aligned timing.
module disp_mixer #(
  parameter int   LAYERS      = 4,
  parameter int   R_W         = 4,
  parameter int   G_W         = 4,
  parameter int   B_W         = 4,
  parameter int   STEP_FRAMES = 2,
  parameter logic SYNC_RST    = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              disp_i,
  input  logic                              h_sync_i,
  input  logic                              v_sync_i,
  input  logic [LAYERS*(R_W+G_W+B_W)-1:0]   layer_rgb_i,
  input  logic [LAYERS-1:0]                 layer_alpha_i,
  input  logic [LAYERS-1:0]                 layer_en_i,
  input  logic [R_W+G_W+B_W-1:0]            bg_rgb_i,
  input  logic [1:0]                        fade_cmd_i,
  input  logic                              fade_start_i,
  output logic                              fade_busy_o,
  output logic [4:0]                        level_o,
  output logic [R_W-1:0]                    vga_r_o,
  output logic [G_W-1:0]                    vga_g_o,
  output logic [B_W-1:0]                    vga_b_o,
  output logic                              h_sync_o,
  output logic                              v_sync_o,
  output logic                              disp_o
);
  localparam int RGB_W = R_W + G_W + B_W;
  typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} state_t;
  state_t           state_q, state_d;
  logic [4:0]       level_q, level_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             vs_hist_q;
  logic             frame_tick;
  logic [RGB_W-1:0] sel, pix_q, pix_d;
  logic             disp1_q, hs1_q, vs1_q;
  logic [R_W+4:0]   r_prod;
  logic [G_W+4:0]   g_prod;
  logic [B_W+4:0]   b_prod;
  logic [R_W-1:0]   r_q, r_d;
  logic [G_W-1:0]   g_q, g_d;
  logic [B_W-1:0]   b_q, b_d;
  logic             disp2_q, hs2_q, vs2_q;
  assign frame_tick = v_sync_i & ~vs_hist_q;
  // lowest enabled opaque layer wins, so scan from the top index down
  always_comb begin
    sel = bg_rgb_i;
    for (int k = LAYERS - 1; k >= 0; k--)
      if (layer_alpha_i[k] & layer_en_i[k]) sel = layer_rgb_i[k*RGB_W +: RGB_W];
    pix_d = disp_i ? sel : '0;
  end
  always_comb begin
    r_prod = (R_W+5)'(pix_q[RGB_W-1 -: R_W]) * (R_W+5)'(level_q);
    g_prod = (G_W+5)'(pix_q[G_W+B_W-1 -: G_W]) * (G_W+5)'(level_q);
    b_prod = (B_W+5)'(pix_q[B_W-1:0]) * (B_W+5)'(level_q);
    r_d = R_W'(r_prod >> 4);
    g_d = G_W'(g_prod >> 4);
    b_d = B_W'(b_prod >> 4);
  end
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:
        if (fade_start_i && (fade_cmd_i == 2'b01 || fade_cmd_i == 2'b10)) begin
          state_d = (fade_cmd_i == 2'b01) ? FADE_OUT : FADE_IN;
          cnt_d   = '0;
        end
      FADE_OUT, FADE_IN:
        if (frame_tick) begin
          if (cnt_q == 8'(STEP_FRAMES - 1)) begin
            cnt_d = '0;
            if (state_q == FADE_OUT) begin
              level_d = (level_q == 5'd0) ? 5'd0 : level_q - 5'd1;
              state_d = (level_d == 5'd0) ? IDLE : state_q;
            end else begin
              level_d = (level_q >= 5'd16) ? 5'd16 : level_q + 5'd1;
              state_d = (level_d == 5'd16) ? IDLE : state_q;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      level_q   <= 5'd16;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      vs_hist_q <= 1'b0;
      pix_q     <= '0;
      disp1_q   <= 1'b0;
      hs1_q     <= SYNC_RST;
      vs1_q     <= SYNC_RST;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      disp2_q   <= 1'b0;
      hs2_q     <= SYNC_RST;
      vs2_q     <= SYNC_RST;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      vs_hist_q <= v_sync_i;
      pix_q     <= pix_d;
      disp1_q   <= disp_i;
      hs1_q     <= h_sync_i;
      vs1_q     <= v_sync_i;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      disp2_q   <= disp1_q;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
    end
  end
  assign fade_busy_o = busy_q;
  assign level_o     = level_q;
  assign vga_r_o     = r_q;
  assign vga_g_o     = g_q;
  assign vga_b_o     = b_q;
  assign disp_o      = disp2_q;
  assign h_sync_o    = hs2_q;
  assign v_sync_o    = vs2_q;
endmodule

// File: tb/tb_disp_mixer.sv
// tb_disp_mixer: directed checks of layer priority, fades and reset for disp_mixer.
module tb_disp_mixer;
  localparam int LAYERS = 4;
  localparam int RGB_W  = 12;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic disp_i = 1'b0, h_sync_i = 1'b0, v_sync_i = 1'b0;
  logic [LAYERS*RGB_W-1:0] layer_rgb_i;
  logic [LAYERS-1:0] layer_alpha_i, layer_en_i;
  logic [RGB_W-1:0] bg_rgb_i;
  logic [1:0] fade_cmd_i = 2'b00;
  logic fade_start_i = 1'b0;
  logic fade_busy_o;
  logic [4:0] level_o;
  logic [3:0] vga_r_o, vga_g_o, vga_b_o;
  logic h_sync_o, v_sync_o, disp_o;
  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];
  disp_mixer dut (
    .clk(clk), .rst_n(rst_n), .disp_i(disp_i), .h_sync_i(h_sync_i), .v_sync_i(v_sync_i),
    .layer_rgb_i(layer_rgb_i), .layer_alpha_i(layer_alpha_i), .layer_en_i(layer_en_i),
    .bg_rgb_i(bg_rgb_i), .fade_cmd_i(fade_cmd_i), .fade_start_i(fade_start_i),
    .fade_busy_o(fade_busy_o), .level_o(level_o), .vga_r_o(vga_r_o), .vga_g_o(vga_g_o),
    .vga_b_o(vga_b_o), .h_sync_o(h_sync_o), .v_sync_o(v_sync_o), .disp_o(disp_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic tick();
    v_sync_i = 1'b1;
    step();
    v_sync_i = 1'b0;
    step();
  endtask
  task automatic start_fade(input logic [1:0] cmd);
    fade_cmd_i   = cmd;
    fade_start_i = 1'b1;
    step();
    fade_start_i = 1'b0;
  endtask
  task automatic send(input logic [11:0] exp);
    exp_q.push_back(exp);
    step();
    step();
    chk("pix", {vga_r_o, vga_g_o, vga_b_o}, exp_q.pop_front());
  endtask
  initial begin
    layer_rgb_i   = {12'h0F0, 12'h888, 12'hF00, 12'h00F};
    layer_alpha_i = 4'b1010;
    layer_en_i    = 4'b1111;
    bg_rgb_i      = 12'h357;
    repeat (3) step();
    chk("rst_vga", {vga_r_o, vga_g_o, vga_b_o}, 12'h000);
    chk("rst_disp", disp_o, 1'b0);
    chk("rst_hs", h_sync_o, 1'b1);
    chk("rst_vs", v_sync_o, 1'b1);
    chk("rst_level", level_o, 5'd16);
    chk("rst_busy", fade_busy_o, 1'b0);
    rst_n = 1'b1;
    step();
    step();
    chk("hs_flow", h_sync_o, 1'b0);
    disp_i = 1'b1;
    exp_q.push_back(12'hF00);
    step();
    chk("lat1_vga", {vga_r_o, vga_g_o, vga_b_o}, 12'h000);
    chk("lat1_disp", disp_o, 1'b0);
    step();
    chk("prio", {vga_r_o, vga_g_o, vga_b_o}, exp_q.pop_front());
    chk("disp_lat2", disp_o, 1'b1);
    h_sync_i = 1'b1;
    step();
    chk("hs_lat1", h_sync_o, 1'b0);
    step();
    chk("hs_lat2", h_sync_o, 1'b1);
    h_sync_i = 1'b0;
    layer_en_i = 4'b1101;
    send(12'h0F0);
    layer_alpha_i = 4'b0000;
    send(12'h357);
    layer_alpha_i = 4'b1010;
    layer_en_i = 4'b1111;
    disp_i = 1'b0;
    send(12'h000);
    disp_i = 1'b1;
    layer_rgb_i = {12'h0F0, 12'h888, 12'hFFF, 12'h00F};
    send(12'hFFF);
    start_fade(2'b01);
    chk("fo_busy0", fade_busy_o, 1'b1);
    chk("fo_level0", level_o, 5'd16);
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk("fo_level", level_o, 16'(16 - i / 2));
      chk("fo_busy", fade_busy_o, i < 32);
      if (i == 16) chk("fo_pix8", {vga_r_o, vga_g_o, vga_b_o}, 12'h777);
    end
    chk("fo_pix0", {vga_r_o, vga_g_o, vga_b_o}, 12'h000);
    tick();
    tick();
    chk("fo_hold", level_o, 5'd0);
    start_fade(2'b10);
    chk("fi_busy0", fade_busy_o, 1'b1);
    chk("fi_level0", level_o, 5'd0);
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk("fi_level", level_o, 16'(i / 2));
      chk("fi_busy", fade_busy_o, i < 32);
    end
    chk("fi_pix", {vga_r_o, vga_g_o, vga_b_o}, 12'hFFF);
    start_fade(2'b11);
    chk("cmd11_busy", fade_busy_o, 1'b0);
    start_fade(2'b00);
    chk("cmd00_busy", fade_busy_o, 1'b0);
    tick();
    tick();
    chk("cmd_ign_level", level_o, 5'd16);
    fade_cmd_i   = 2'b01;
    fade_start_i = 1'b1;
    v_sync_i     = 1'b1;
    step();
    fade_start_i = 1'b0;
    v_sync_i     = 1'b0;
    step();
    chk("coin_busy", fade_busy_o, 1'b1);
    tick();
    chk("coin_t1", level_o, 5'd16);
    tick();
    chk("coin_t2", level_o, 5'd15);
    start_fade(2'b10);
    chk("mid_busy", fade_busy_o, 1'b1);
    chk("mid_level", level_o, 5'd15);
    tick();
    chk("mid_t1", level_o, 5'd15);
    tick();
    chk("mid_t2", level_o, 5'd14);
    repeat (18) tick();
    chk("lvl5", level_o, 5'd5);
    chk("lvl5_busy", fade_busy_o, 1'b1);
    chk("lvl5_pix", {vga_r_o, vga_g_o, vga_b_o}, 12'h444);
    rst_n = 1'b0;
    step();
    chk("mrst_level", level_o, 5'd16);
    chk("mrst_busy", fade_busy_o, 1'b0);
    chk("mrst_vga", {vga_r_o, vga_g_o, vga_b_o}, 12'h000);
    chk("mrst_disp", disp_o, 1'b0);
    chk("mrst_hs", h_sync_o, 1'b1);
    chk("mrst_vs", v_sync_o, 1'b1);
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_pix", {vga_r_o, vga_g_o, vga_b_o}, 12'hFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/disp_mixer.md
DISP_MIXER -- requirements
Module: disp_mixer

Interface
REQ-001 The block SHALL have parameter LAYERS, default 4, meaning number of sprite layers (1..8).
REQ-002 The block SHALL have parameter R_W / G_W / B_W, default 4 / 4 / 4, meaning per-channel colour width; RGB_W = R_W+G_W+B_W.
REQ-003 The block SHALL have parameter STEP_FRAMES, default 2, meaning frames per fade step (1..255).
REQ-004 The block SHALL have parameter SYNC_RST, default 1'b1, meaning reset value of h_sync_o/v_sync_o.
REQ-005 The block SHALL have port clk, input, 1 bit: pixel clock; all logic on rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have ports disp_i, h_sync_i and v_sync_i, input, 1 bit each: timing from the VGA driver, aligned with the layer inputs.
REQ-008 The block SHALL have port layer_rgb_i, input, LAYERS*RGB_W bits: layer k occupies bits [k*RGB_W +: RGB_W], ordered {R,G,B}.
REQ-009 The block SHALL have port layer_alpha_i, input, LAYERS bits: bit k high means layer k is opaque at this pixel.
REQ-010 The block SHALL have port layer_en_i, input, LAYERS bits: bit k low masks layer k entirely.
REQ-011 The block SHALL have port bg_rgb_i, input, RGB_W bits: background colour.
REQ-012 The block SHALL have ports fade_cmd_i (input, 2 bits) and fade_start_i (input, 1 bit): fade command (01 fade-out, 10 fade-in, 00/11 none) and start pulse.
REQ-013 The block SHALL have port fade_busy_o, output, 1 bit: high while a fade is in progress.
REQ-014 The block SHALL have port level_o, output, 5 bits: current brightness level, 0..16.
REQ-015 The block SHALL have ports vga_r_o, vga_g_o and vga_b_o, output, R_W, G_W and B_W bits: pixel colour.
REQ-016 The block SHALL have ports h_sync_o, v_sync_o and disp_o, output, 1 bit each: timing delayed to match the colour outputs.

Function
REQ-017 Stage 1 SHALL register the winner: the lowest index k with layer_alpha_i[k] & layer_en_i[k], else bg_rgb_i.
REQ-018 Stage 1 SHALL force the selected colour to 0 when disp_i is low.
REQ-019 Stage 2 SHALL register each channel as (c * level) >> 4, using a product of channel width + 5 bits and truncating the result to channel width.
REQ-020 Level 16 SHALL reproduce c exactly, level 0 SHALL give 0, and overflow SHALL NOT be possible.
REQ-021 disp, h_sync and v_sync SHALL pass through two register stages, so all outputs have a fixed latency of 2 clocks from the inputs.
REQ-022 frame_tick SHALL be a one-cycle pulse on a rising edge of v_sync_i, detected with one registered copy of v_sync_i.
REQ-023 The fade FSM SHALL have states IDLE, FADE_OUT and FADE_IN; fade_busy_o SHALL be high in FADE_OUT and FADE_IN.
REQ-024 In IDLE, fade_start_i with cmd 01 SHALL go to FADE_OUT and fade_start_i with cmd 10 SHALL go to FADE_IN; on entry the frame counter SHALL be cleared.
REQ-025 In IDLE, fade_start_i with cmd 00 or 11 SHALL be ignored.
REQ-026 fade_start_i while busy SHALL be ignored.
REQ-027 In FADE_OUT or FADE_IN, each frame_tick SHALL increment the frame counter; when it reaches STEP_FRAMES-1 it SHALL clear and the level SHALL step by 1, down in FADE_OUT and up in FADE_IN.
REQ-028 FADE_OUT SHALL return to IDLE in the cycle level becomes 0, and the level SHALL then hold 0.
REQ-029 FADE_IN SHALL return to IDLE in the cycle level becomes 16.
REQ-030 Fade-out started at level 0 SHALL enter FADE_OUT and exit on the first step with level held at 0 (no underflow).
REQ-031 Fade-in started at level 16 SHALL behave symmetrically and SHALL NOT exceed 16.
REQ-032 When fade_start_i and frame_tick occur in the same cycle in IDLE, the start SHALL be taken and the tick SHALL NOT count.
REQ-033 A level change SHALL take effect on the stage-2 multiply in the cycle after it updates, including mid-line.

Reset
REQ-034 While rst_n is low at a clk edge, all pipeline registers, vga_*_o and disp_o SHALL be 0.
REQ-035 While rst_n is low at a clk edge, h_sync_o and v_sync_o SHALL equal SYNC_RST.
REQ-036 While rst_n is low at a clk edge, the FSM SHALL be IDLE, level SHALL be 16, the frame counter SHALL be 0 and the v_sync history SHALL be 0.
REQ-037 Reset asserted mid-fade SHALL abort the fade and restore level 16 on the same edge.

Verification
REQ-038 The bench SHALL check priority: LAYERS=4, alpha=4'b1010, en=4'b1111, layer1=12'hF00, layer3=12'h0F0, disp_i=1 -> vga = F,0,0 exactly 2 clocks later.
REQ-039 The bench SHALL check masking: same stimulus with en=4'b1101 -> vga = 0,F,0; with alpha=0 -> vga = bg_rgb_i; with disp_i=0 -> vga = 0.
REQ-040 The bench SHALL check fade-out: STEP_FRAMES=2, fade_start_i with cmd 01, then 32 v_sync_i rising edges -> level 16,15,...,0, one step per 2 ticks; busy drops when level reaches 0; pixel F at level 8 -> 7.
REQ-041 The bench SHALL check fade-in from 0: 32 ticks -> level reaches 16, busy drops, and output equals input colour.
REQ-042 The bench SHALL check ignored commands: fade_start_i with cmd 11, and fade_start_i pulsed mid-fade -> no state change; start coincident with a tick -> the first step needs a full STEP_FRAMES further ticks.
REQ-043 The bench SHALL check reset mid-fade: rst_n low for 1 clk at level 5 -> level 16, busy 0, outputs 0, syncs equal SYNC_RST.
